// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared CDB types, ROB constants and ROB age helper
package types_pkg;

    localparam int ROB_DEPTH   = 16;
    localparam int ROB_IDX_W   = 5;
    localparam int DEF_PREG_W  = 7;
    localparam int DEF_XLEN    = 32;

    typedef struct packed {
        logic                  valid;
        logic [DEF_PREG_W-1:0] pd;
        logic [ROB_IDX_W-1:0]  rob_index;
        logic [DEF_XLEN-1:0]   data;
    } cdb_data_t;

    // Distance of a ROB index from the head, modulo the ROB size; larger is younger.
    function automatic logic [ROB_IDX_W-1:0] rob_age(
        input logic [ROB_IDX_W-1:0] idx,
        input logic [ROB_IDX_W-1:0] head,
        input int                   depth
    );
        int diff;
        diff = (int'(idx) - int'(head)) % depth;
        if (diff < 0) begin
            diff = diff + depth;
        end
        return ROB_IDX_W'(diff);
    endfunction

endpackage

// File: rtl/cdb_skid_fifo.sv
// rtl/cdb_skid_fifo.sv - 2-entry per-FU result buffer with squash-by-age and compaction
module cdb_skid_fifo
    import types_pkg::*;
#(
    parameter int PREG_W    = 7,
    parameter int XLEN      = 32,
    parameter int ROB_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [PREG_W-1:0] push_pd,
    input  logic [4:0]        push_rob,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              flush,
    input  logic [4:0]        flush_tag,
    input  logic [4:0]        rob_head,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [PREG_W-1:0] head_pd,
    output logic [4:0]        head_rob,
    output logic [XLEN-1:0]   head_data
);

    logic [1:0]        v_q;
    logic [PREG_W-1:0] pd_q   [2];
    logic [4:0]        rob_q  [2];
    logic [XLEN-1:0]   data_q [2];

    logic              keep0, keep1, push_ok;
    logic [4:0]        tag_age;
    logic              n_v0, n_v1;
    logic [PREG_W-1:0] n_pd0, n_pd1;
    logic [4:0]        n_rob0, n_rob1;
    logic [XLEN-1:0]   n_data0, n_data1;

    assign count = {1'b0, v_q[0]} + {1'b0, v_q[1]};

    // Squash younger entries, expose the surviving head, then compact, pop and append.
    always_comb begin
        tag_age = rob_age(flush_tag, rob_head, ROB_DEPTH);
        keep0   = v_q[0] && !(flush && (rob_age(rob_q[0], rob_head, ROB_DEPTH) > tag_age));
        keep1   = v_q[1] && !(flush && (rob_age(rob_q[1], rob_head, ROB_DEPTH) > tag_age));
        push_ok = push && !(flush && (rob_age(push_rob, rob_head, ROB_DEPTH) > tag_age));

        head_valid = keep0 || keep1;
        head_pd    = keep0 ? pd_q[0]   : pd_q[1];
        head_rob   = keep0 ? rob_q[0]  : rob_q[1];
        head_data  = keep0 ? data_q[0] : data_q[1];

        n_v0    = keep0 || keep1;
        n_pd0   = head_pd;
        n_rob0  = head_rob;
        n_data0 = head_data;
        n_v1    = keep0 && keep1;
        n_pd1   = pd_q[1];
        n_rob1  = rob_q[1];
        n_data1 = data_q[1];

        if (pop) begin
            n_v0    = n_v1;
            n_pd0   = n_pd1;
            n_rob0  = n_rob1;
            n_data0 = n_data1;
            n_v1    = 1'b0;
        end

        if (push_ok) begin
            if (!n_v0) begin
                n_v0    = 1'b1;
                n_pd0   = push_pd;
                n_rob0  = push_rob;
                n_data0 = push_data;
            end else begin
                n_v1    = 1'b1;
                n_pd1   = push_pd;
                n_rob1  = push_rob;
                n_data1 = push_data;
            end
        end
    end

    // Buffer state register; reset only needs to clear the valid bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 2'b00;
        end else begin
            v_q       <= {n_v1, n_v0};
            pd_q[0]   <= n_pd0;
            pd_q[1]   <= n_pd1;
            rob_q[0]  <= n_rob0;
            rob_q[1]  <= n_rob1;
            data_q[0] <= n_data0;
            data_q[1] <= n_data1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbitration of FU results onto a registered CDB
module cdb_arbiter
    import types_pkg::*;
#(
    parameter int N_FU      = 3,
    parameter int ROB_DEPTH = types_pkg::ROB_DEPTH,
    parameter int PREG_W    = 7,
    parameter int XLEN      = 32,
    localparam int SRC_W    = (N_FU > 1) ? $clog2(N_FU) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_FU-1:0]        req_valid,
    output logic [N_FU-1:0]        req_ready,
    input  logic [N_FU*PREG_W-1:0] req_pd,
    input  logic [N_FU*5-1:0]      req_rob,
    input  logic [N_FU*XLEN-1:0]   req_data,
    input  logic [4:0]             rob_head,
    input  logic                   mispredict,
    input  logic [4:0]             mispredict_tag,
    output logic                   cdb_valid,
    output logic [PREG_W-1:0]      cdb_pd,
    output logic [4:0]             cdb_rob,
    output logic [XLEN-1:0]        cdb_data,
    output logic [SRC_W-1:0]       cdb_src
);

    logic [1:0]        fifo_count [N_FU];
    logic [N_FU-1:0]   head_valid;
    logic [N_FU-1:0]   pop;
    logic [PREG_W-1:0] head_pd    [N_FU];
    logic [4:0]        head_rob   [N_FU];
    logic [XLEN-1:0]   head_data  [N_FU];

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W-1:0]  rr_next;
    logic              found;

    for (genvar g = 0; g < N_FU; g++) begin : g_fu
        assign req_ready[g] = !reset && (fifo_count[g] != 2'd2);

        cdb_skid_fifo #(
            .PREG_W    (PREG_W),
            .XLEN      (XLEN),
            .ROB_DEPTH (ROB_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (req_valid[g] && req_ready[g]),
            .push_pd    (req_pd[g*PREG_W +: PREG_W]),
            .push_rob   (req_rob[g*5 +: 5]),
            .push_data  (req_data[g*XLEN +: XLEN]),
            .pop        (pop[g]),
            .flush      (mispredict),
            .flush_tag  (mispredict_tag),
            .rob_head   (rob_head),
            .count      (fifo_count[g]),
            .head_valid (head_valid[g]),
            .head_pd    (head_pd[g]),
            .head_rob   (head_rob[g]),
            .head_data  (head_data[g])
        );
    end

    // Round-robin search from rr_ptr over buffers that still hold a surviving result.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        pop    = '0;
        for (int k = 0; k < N_FU; k++) begin
            if (!found && head_valid[(int'(rr_ptr) + k) % N_FU]) begin
                found  = 1'b1;
                winner = SRC_W'((int'(rr_ptr) + k) % N_FU);
            end
        end
        if (found) begin
            pop[winner] = 1'b1;
        end
        rr_next = (int'(winner) == N_FU - 1) ? '0 : winner + 1'b1;
    end

    // CDB register: one broadcast per cycle, fields hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            cdb_valid <= 1'b0;
            cdb_pd    <= '0;
            cdb_rob   <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (found) begin
            rr_ptr    <= rr_next;
            cdb_valid <= 1'b1;
            cdb_pd    <= head_pd[winner];
            cdb_rob   <= head_rob[winner];
            cdb_data  <= head_data[winner];
            cdb_src   <= winner;
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

    localparam int N_FU   = 3;
    localparam int PREG_W = 7;
    localparam int XLEN   = 32;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_FU-1:0]        req_valid;
    logic [N_FU-1:0]        req_ready;
    logic [N_FU*PREG_W-1:0] req_pd;
    logic [N_FU*5-1:0]      req_rob;
    logic [N_FU*XLEN-1:0]   req_data;
    logic [4:0]             rob_head;
    logic                   mispredict;
    logic [4:0]             mispredict_tag;
    logic                   cdb_valid;
    logic [PREG_W-1:0]      cdb_pd;
    logic [4:0]             cdb_rob;
    logic [XLEN-1:0]        cdb_data;
    logic [1:0]             cdb_src;

    int vectors     = 0;
    int miscompares = 0;

    cdb_arbiter #(.N_FU(N_FU), .ROB_DEPTH(16), .PREG_W(PREG_W), .XLEN(XLEN)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pd         (req_pd),
        .req_rob        (req_rob),
        .req_data       (req_data),
        .rob_head       (rob_head),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .cdb_valid      (cdb_valid),
        .cdb_pd         (cdb_pd),
        .cdb_rob        (cdb_rob),
        .cdb_data       (cdb_data),
        .cdb_src        (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int fu, input int pd, input int rob, input logic [31:0] data);
        req_valid[fu]              = 1'b1;
        req_pd[fu*PREG_W +: PREG_W] = PREG_W'(pd);
        req_rob[fu*5 +: 5]          = 5'(rob);
        req_data[fu*XLEN +: XLEN]   = data;
    endtask

    task automatic idle();
        req_valid = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_cdb(input string tag, input int pd, input int rob,
                              input logic [31:0] data, input int src);
        check({tag, ".valid"}, 64'(cdb_valid), 64'd1);
        check({tag, ".pd"},    64'(cdb_pd),    64'(pd));
        check({tag, ".rob"},   64'(cdb_rob),   64'(rob));
        check({tag, ".data"},  64'(cdb_data),  64'(data));
        check({tag, ".src"},   64'(cdb_src),   64'(src));
    endtask

    int ord2 [3] = '{2, 0, 1};
    int alu_in [5] = '{0, 1, 2, 3, 3};
    int lsu_in [5] = '{0, 1, 2, 2, -1};
    int exp_src [7] = '{0, 2, 0, 2, 0, 2, 0};
    int exp_k   [7] = '{0, 0, 1, 1, 2, 2, 3};
    logic [2:0] exp_rdy [3] = '{3'b011, 3'b110, 3'b011};

    initial begin
        reset          = 1'b1;
        req_valid      = '0;
        req_pd         = '0;
        req_rob        = '0;
        req_data       = '0;
        rob_head       = 5'd0;
        mispredict     = 1'b0;
        mispredict_tag = 5'd0;

        // Reset state
        tick();
        tick();
        check("rst.valid", 64'(cdb_valid), 64'd0);
        check("rst.pd",    64'(cdb_pd),    64'd0);
        check("rst.rob",   64'(cdb_rob),   64'd0);
        check("rst.data",  64'(cdb_data),  64'd0);
        check("rst.src",   64'(cdb_src),   64'd0);
        check("rst.ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("post_rst.ready", 64'(req_ready), 64'b111);

        // Single result: push at e1, visible after e2, gone after e3
        drive(0, 5, 3, 32'hDEAD);
        tick();
        idle();
        check("single.e1.valid", 64'(cdb_valid), 64'd0);
        tick();
        expect_cdb("single.e2", 5, 3, 32'hDEAD, 0);
        tick();
        check("single.e3.valid", 64'(cdb_valid), 64'd0);
        check("single.e3.hold_pd", 64'(cdb_pd), 64'd5);

        // Contention from rr_ptr = 0
        do_reset();
        for (int i = 0; i < 3; i++) drive(i, 10 + i, i, 32'(100 + i));
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_cdb($sformatf("rr0.%0d", i), 10 + i, i, 32'(100 + i), i);
        end
        tick();
        check("rr0.idle", 64'(cdb_valid), 64'd0);

        // Contention from rr_ptr = 2 (FU1 wins once first)
        do_reset();
        drive(1, 30, 6, 32'h30);
        tick();
        idle();
        tick();
        expect_cdb("rr2.pre", 30, 6, 32'h30, 1);
        tick();
        for (int i = 0; i < 3; i++) drive(i, 10 + i, i, 32'(100 + i));
        tick();
        idle();
        for (int j = 0; j < 3; j++) begin
            tick();
            expect_cdb($sformatf("rr2.%0d", j), 10 + ord2[j], ord2[j], 32'(100 + ord2[j]), ord2[j]);
        end

        // Full buffer: LSU pushes three results while ALU floods
        do_reset();
        for (int e = 0; e < 5; e++) begin
            drive(0, 20 + alu_in[e], alu_in[e], 32'hA000_0000 + 32'(alu_in[e]));
            if (lsu_in[e] >= 0) drive(2, 40 + lsu_in[e], 8 + lsu_in[e], 32'hB000_0000 + 32'(lsu_in[e]));
            else req_valid[2] = 1'b0;
            tick();
            if (e >= 1) begin
                if (exp_src[e-1] == 2)
                    expect_cdb($sformatf("full.%0d", e - 1), 40 + exp_k[e-1], 8 + exp_k[e-1],
                               32'hB000_0000 + 32'(exp_k[e-1]), 2);
                else
                    expect_cdb($sformatf("full.%0d", e - 1), 20 + exp_k[e-1], exp_k[e-1],
                               32'hA000_0000 + 32'(exp_k[e-1]), 0);
            end
            if (e >= 1 && e <= 3) check($sformatf("full.ready.%0d", e), 64'(req_ready), 64'(exp_rdy[e-1]));
        end
        idle();
        for (int e = 5; e < 8; e++) begin
            tick();
            if (exp_src[e-1] == 2)
                expect_cdb($sformatf("full.%0d", e - 1), 40 + exp_k[e-1], 8 + exp_k[e-1],
                           32'hB000_0000 + 32'(exp_k[e-1]), 2);
            else
                expect_cdb($sformatf("full.%0d", e - 1), 20 + exp_k[e-1], exp_k[e-1],
                           32'hA000_0000 + 32'(exp_k[e-1]), 0);
        end
        tick();
        check("full.idle", 64'(cdb_valid), 64'd0);

        // Flush with wrap: head 14, tag 1
        do_reset();
        rob_head = 5'd14;
        drive(0, 50, 14, 32'hF000_000E);
        drive(1, 51, 1,  32'hF000_0001);
        drive(2, 52, 2,  32'hF000_0002);
        tick();
        idle();
        drive(0, 53, 3,  32'hF000_0003);
        drive(2, 54, 15, 32'hF000_000F);
        tick();
        idle();
        expect_cdb("flush.old", 50, 14, 32'hF000_000E, 0);
        mispredict     = 1'b1;
        mispredict_tag = 5'd1;
        drive(0, 55, 4, 32'hF000_0004);
        tick();
        idle();
        mispredict = 1'b0;
        expect_cdb("flush.branch", 51, 1, 32'hF000_0001, 1);
        check("flush.ready", 64'(req_ready), 64'b111);
        tick();
        expect_cdb("flush.survivor", 54, 15, 32'hF000_000F, 2);
        tick();
        check("flush.idle0", 64'(cdb_valid), 64'd0);
        tick();
        check("flush.idle1", 64'(cdb_valid), 64'd0);

        // Reset mid-stream with four results buffered
        rob_head = 5'd0;
        do_reset();
        for (int i = 0; i < 3; i++) drive(i, 60 + i, 4 + i, 32'(600 + i));
        tick();
        idle();
        drive(1, 63, 7, 32'd603);
        drive(2, 64, 8, 32'd604);
        tick();
        idle();
        expect_cdb("midrst.pre", 60, 4, 32'd600, 0);
        reset = 1'b1;
        tick();
        check("midrst.valid", 64'(cdb_valid), 64'd0);
        check("midrst.pd",    64'(cdb_pd),    64'd0);
        check("midrst.rob",   64'(cdb_rob),   64'd0);
        check("midrst.data",  64'(cdb_data),  64'd0);
        check("midrst.src",   64'(cdb_src),   64'd0);
        check("midrst.ready", 64'(req_ready), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("midrst.after.%0d", i), 64'(cdb_valid), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
